// File: rtl/bcd_time_pkg.sv
// rtl/bcd_time_pkg.sv - shared types, digit limits and helpers for bcd_time_counter
// Purpose : BCD digit typedef, per-field digit maxima, load validation and
//           24h -> 12h hour conversion used by bcd_time_counter.
// Ports   : none (package).
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t FRAC_MAX     = 4'd9;
  localparam bcd_digit_t UNITS_MAX    = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t MIN_TENS_MAX = 4'd5;
  localparam logic [7:0] HOUR_MAX_BCD = 8'h23;

  // value is {h2,h1,m2,m1,s2,s1,f2,f1,f0}; fraction digits that the
  // instance does not have are supplied as zero and therefore always pass.
  function automatic logic bcd_valid(input logic [35:0] value);
    logic ok;
    ok = (value[35:28] <= HOUR_MAX_BCD) && (value[31:28] <= UNITS_MAX)
      && (value[27:24] <= MIN_TENS_MAX) && (value[23:20] <= UNITS_MAX)
      && (value[19:16] <= SEC_TENS_MAX) && (value[15:12] <= UNITS_MAX)
      && (value[11:8]  <= FRAC_MAX)     && (value[7:4]   <= FRAC_MAX)
      && (value[3:0]   <= FRAC_MAX);
    return ok;
  endfunction

  // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11
  function automatic logic [7:0] hour_to_12(input logic [7:0] h);
    logic [4:0] bin;
    logic [4:0] adj;
    bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    adj = bin - 5'd12;
    if (bin == 5'd0)  return 8'h12;
    if (bin <= 5'd12) return h;
    if (adj >= 5'd10) return {4'd1, 4'(adj - 5'd10)};
    return {4'd0, adj[3:0]};
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one up/down BCD digit with load, carry and borrow
// Purpose : single decade digit counting 0..MAX in either direction.
// Ports   : clk_i, rst_i (async, active-high); en_i advance; dir_i 0=up 1=down;
//           load_i/load_val_i synchronous load (priority over en_i);
//           digit_o current value; carry_o at MAX going up; borrow_o at 0 going down.
module bcd_digit_cell
  import bcd_time_pkg::*;
#(
  parameter bcd_digit_t MAX = 4'd9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  output bcd_digit_t digit_o,
  output logic       carry_o,
  output logic       borrow_o
);

  bcd_digit_t r_digit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_digit <= '0;
    end else if (load_i) begin
      r_digit <= load_val_i;
    end else if (en_i) begin
      if (dir_i) r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 4'd1;
      else       r_digit <= (r_digit == MAX) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit_o  = r_digit;
  assign carry_o  = ~dir_i & (r_digit == MAX);
  assign borrow_o =  dir_i & (r_digit == 4'd0);

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - parametrised up/down BCD time-of-day counter
// Purpose : 24-hour BCD time state with FRAC_DIGITS sub-second digits, tick
//           advance, countdown saturating at zero, validated load, 12/24h display.
// Ports   : clk_i, rst_i (async, active-high); tick_i advance strobe; dir_i 0=up 1=down;
//           mode12_i 12-hour display; load_i/load_val_i validated load;
//           count_o displayed time; pm_o hour>=12; zero_o all digits 0;
//           sec_pulse_o, wrap_o, load_err_o, alarm_o one-cycle event pulses.
// Option  : BCD_TIME_ALARM_EN adds alarm_val_i/alarm_arm_i and drives alarm_o.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter  int FRAC_DIGITS = 3,
  localparam int W           = 24 + 4 * FRAC_DIGITS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic         dir_i,
  input  logic         mode12_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
`ifdef BCD_TIME_ALARM_EN
  input  logic [23:0]  alarm_val_i,
  input  logic         alarm_arm_i,
`endif
  output logic [W-1:0] count_o,
  output logic         pm_o,
  output logic         zero_o,
  output logic         sec_pulse_o,
  output logic         wrap_o,
  output logic         load_err_o,
  output logic         alarm_o
);

  // digits below the hour pair: fraction, s1, s2, m1, m2 (index 0 = LSD)
  localparam int N = FRAC_DIGITS + 4;

  logic [4*N-1:0] w_low;
  logic [N-1:0]   w_carry;
  logic [N-1:0]   w_borrow;
  logic [N:0]     w_ripple;
  logic [35:0]    w_load_pad;
  logic           w_load_ok;
  logic           w_zero;
  logic           w_tick_ok;
  logic           w_hour_en;
  logic [7:0]     w_hour_nxt;
  logic [7:0]     r_hour;
  logic           r_sec_pulse;
  logic           r_wrap;
  logic           r_load_err;

  assign w_load_pad = 36'(load_val_i) << (4 * (3 - FRAC_DIGITS));
  assign w_load_ok  = load_i & bcd_valid(w_load_pad);
  assign w_zero     = (r_hour == 8'h00) && (w_low == '0);
  // load wins over tick; a countdown at all-zero ignores the tick entirely
  assign w_tick_ok  = tick_i & ~load_i & ~(dir_i & w_zero);

  assign w_ripple[0] = w_tick_ok;

  for (genvar i = 0; i < N; i++) begin : g_digit
    localparam int         POS = i - FRAC_DIGITS;
    localparam bcd_digit_t MAX = (i < FRAC_DIGITS) ? FRAC_MAX :
                                 (POS == 1) ? SEC_TENS_MAX :
                                 (POS == 3) ? MIN_TENS_MAX : UNITS_MAX;
    bcd_digit_cell #(.MAX(MAX)) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (w_ripple[i]),
      .dir_i      (dir_i),
      .load_i     (w_load_ok),
      .load_val_i (load_val_i[4*i +: 4]),
      .digit_o    (w_low[4*i +: 4]),
      .carry_o    (w_carry[i]),
      .borrow_o   (w_borrow[i])
    );
    assign w_ripple[i+1] = w_ripple[i] & (w_carry[i] | w_borrow[i]);
  end

  assign w_hour_en = w_ripple[N];

  always_comb begin
    w_hour_nxt = r_hour;
    if (w_hour_en) begin
      if (!dir_i) begin
        if (r_hour == HOUR_MAX_BCD)   w_hour_nxt = 8'h00;
        else if (r_hour[3:0] == 4'd9) w_hour_nxt = {r_hour[7:4] + 4'd1, 4'd0};
        else                          w_hour_nxt = {r_hour[7:4], r_hour[3:0] + 4'd1};
      end else if (r_hour != 8'h00) begin
        // hour 00 has no higher field to borrow from, so it holds
        if (r_hour[3:0] == 4'd0) w_hour_nxt = {r_hour[7:4] - 4'd1, 4'd9};
        else                     w_hour_nxt = {r_hour[7:4], r_hour[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hour      <= 8'h00;
      r_sec_pulse <= 1'b0;
      r_wrap      <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_hour      <= w_load_ok ? load_val_i[W-1 -: 8] : w_hour_nxt;
      // carry/borrow out of the fraction field; with no fraction it is the tick itself
      r_sec_pulse <= w_ripple[FRAC_DIGITS];
      r_wrap      <= w_hour_en & ~dir_i & (r_hour == HOUR_MAX_BCD);
      r_load_err  <= load_i & ~w_load_ok;
    end
  end

`ifdef BCD_TIME_ALARM_EN
  localparam logic [4*N-1:0] FRAC_MASK = (4*N)'((64'd1 << (4 * FRAC_DIGITS)) - 64'd1);
  logic        r_alarm_chk;
  logic [23:0] r_alarm_val;

  // remember that the last edge applied an armed tick; the state now shown is
  // the result of that tick, so the match is taken against it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alarm_chk <= 1'b0;
      r_alarm_val <= '0;
    end else begin
      r_alarm_chk <= w_tick_ok & alarm_arm_i;
      r_alarm_val <= alarm_val_i;
    end
  end

  assign alarm_o = r_alarm_chk && ((w_low & FRAC_MASK) == '0)
                && ({r_hour, w_low[4*N-1 -: 16]} == r_alarm_val);
`else
  assign alarm_o = 1'b0;
`endif

  assign count_o     = {(mode12_i ? hour_to_12(r_hour) : r_hour), w_low};
  assign pm_o        = (r_hour >= 8'h12);
  assign zero_o      = w_zero;
  assign sec_pulse_o = r_sec_pulse;
  assign wrap_o      = r_wrap;
  assign load_err_o  = r_load_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed self-checking bench for bcd_time_counter
module tb_bcd_time_counter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tick_i = 1'b0;
  logic        dir_i = 1'b0;
  logic        mode12_i = 1'b0;
  logic        load_i = 1'b0;
  logic [35:0] load_val_i = '0;
  logic [23:0] alarm_val_i = '0;
  logic        alarm_arm_i = 1'b0;
  logic [35:0] count_o;
  logic        pm_o, zero_o, sec_pulse_o, wrap_o, load_err_o, alarm_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bcd_time_counter #(.FRAC_DIGITS(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tick_i      (tick_i),
    .dir_i       (dir_i),
    .mode12_i    (mode12_i),
    .load_i      (load_i),
    .load_val_i  (load_val_i),
`ifdef BCD_TIME_ALARM_EN
    .alarm_val_i (alarm_val_i),
    .alarm_arm_i (alarm_arm_i),
`endif
    .count_o     (count_o),
    .pm_o        (pm_o),
    .zero_o      (zero_o),
    .sec_pulse_o (sec_pulse_o),
    .wrap_o      (wrap_o),
    .load_err_o  (load_err_o),
    .alarm_o     (alarm_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [35:0] v);
    load_i = 1'b1;
    load_val_i = v;
    step();
    load_i = 1'b0;
  endtask

  task automatic do_tick();
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (count_o !== 36'h0) begin $display("FAIL reset_count got %h want %h", count_o, 36'h0); n_err++; end
    n_vec++; if ({zero_o, pm_o, sec_pulse_o, wrap_o, load_err_o, alarm_o} !== 6'b100000) begin
      $display("FAIL reset_flags got %b want %b", {zero_o, pm_o, sec_pulse_o, wrap_o, load_err_o, alarm_o}, 6'b100000); n_err++; end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_up_1000();
    int pulses = 0;
    int at = -1;
    int alarms = 0;
    dir_i = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      do_tick();
      if (sec_pulse_o === 1'b1) begin pulses++; at = i; end
      if (alarm_o !== 1'b0) alarms++;
    end
    n_vec++; if (count_o !== 36'h000001000) begin $display("FAIL up1000_count got %h want %h", count_o, 36'h000001000); n_err++; end
    n_vec++; if (pulses !== 1) begin $display("FAIL up1000_pulses got %0d want 1", pulses); n_err++; end
    n_vec++; if (at !== 999) begin $display("FAIL up1000_pulse_tick got %0d want 999", at); n_err++; end
`ifndef BCD_TIME_ALARM_EN
    n_vec++; if (alarms !== 0) begin $display("FAIL alarm_tied got %0d want 0", alarms); n_err++; end
`endif
  endtask

  task automatic test_carries();
    logic [35:0] from_v [4] = '{36'h235959999, 36'h000059999, 36'h095959999, 36'h195959999};
    logic [35:0] to_v   [4] = '{36'h000000000, 36'h000100000, 36'h100000000, 36'h200000000};
    logic        wrap_v [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    dir_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_load(from_v[k]);
      do_tick();
      n_vec++; if (count_o !== to_v[k]) begin $display("FAIL carry%0d_count got %h want %h", k, count_o, to_v[k]); n_err++; end
      n_vec++; if ({wrap_o, sec_pulse_o} !== {wrap_v[k], 1'b1}) begin
        $display("FAIL carry%0d_pulses got %b want %b", k, {wrap_o, sec_pulse_o}, {wrap_v[k], 1'b1}); n_err++; end
      if (k == 0) begin
        n_vec++; if (zero_o !== 1'b1) begin $display("FAIL wrap_zero got %b want 1", zero_o); n_err++; end
        step();
        n_vec++; if (wrap_o !== 1'b0) begin $display("FAIL wrap_single got %b want 0", wrap_o); n_err++; end
      end
    end
  endtask

  task automatic test_down();
    logic [35:0] exp_v [5] = '{36'h000000001, 36'h000000000, 36'h000000000, 36'h000000000, 36'h000000000};
    int bad_pulse = 0;
    dir_i = 1'b1;
    do_load(36'h000000002);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      n_vec++; if (count_o !== exp_v[i]) begin $display("FAIL down_tick%0d got %h want %h", i, count_o, exp_v[i]); n_err++; end
      if (wrap_o !== 1'b0 || sec_pulse_o !== 1'b0) bad_pulse++;
    end
    n_vec++; if (zero_o !== 1'b1) begin $display("FAIL down_zero got %b want 1", zero_o); n_err++; end
    n_vec++; if (bad_pulse !== 0) begin $display("FAIL down_pulses got %0d want 0", bad_pulse); n_err++; end
    do_load(36'h100000000);
    do_tick();
    n_vec++; if (count_o !== 36'h095959999) begin $display("FAIL down_borrow got %h want %h", count_o, 36'h095959999); n_err++; end
    n_vec++; if ({sec_pulse_o, wrap_o} !== 2'b10) begin $display("FAIL down_borrow_pulse got %b want 10", {sec_pulse_o, wrap_o}); n_err++; end
    dir_i = 1'b0;
  endtask

  task automatic test_mode12();
    logic [7:0] h_in  [6] = '{8'h00, 8'h01, 8'h12, 8'h13, 8'h22, 8'h23};
    logic [7:0] h_out [6] = '{8'h12, 8'h01, 8'h12, 8'h01, 8'h10, 8'h11};
    logic       pm    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    mode12_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_load({h_in[k], 28'h0500000});
      n_vec++; if ({count_o, pm_o} !== {h_out[k], 28'h0500000, pm[k]}) begin
        $display("FAIL mode12_h%h got %h/%b want %h/%b", h_in[k], count_o, pm_o, {h_out[k], 28'h0500000}, pm[k]); n_err++; end
    end
    do_load(36'h130500000);
    mode12_i = 1'b0;
    #1;
    n_vec++; if ({count_o, pm_o} !== {36'h130500000, 1'b1}) begin
      $display("FAIL mode24_h13 got %h/%b want %h/1", count_o, pm_o, 36'h130500000); n_err++; end
  endtask

  task automatic test_load_err();
    logic [35:0] bad [3] = '{36'h126000000, 36'h240000000, 36'h00000000A};
    do_load(36'h083015500);
    for (int k = 0; k < 3; k++) begin
      do_load(bad[k]);
      n_vec++; if ({count_o, load_err_o} !== {36'h083015500, 1'b1}) begin
        $display("FAIL load_err%0d got %h/%b want %h/1", k, count_o, load_err_o, 36'h083015500); n_err++; end
    end
    step();
    n_vec++; if (load_err_o !== 1'b0) begin $display("FAIL load_err_single got %b want 0", load_err_o); n_err++; end
    tick_i = 1'b1;
    do_load(36'h111111111);
    tick_i = 1'b0;
    n_vec++; if ({count_o, sec_pulse_o, load_err_o} !== {36'h111111111, 2'b00}) begin
      $display("FAIL load_tick got %h/%b want %h/00", count_o, {sec_pulse_o, load_err_o}, 36'h111111111); n_err++; end
  endtask

  task automatic test_async_reset();
    load_i = 1'b1;
    load_val_i = 36'h990000000;
    step();
    load_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    n_vec++; if ({count_o, zero_o, load_err_o} !== {36'h0, 2'b10}) begin
      $display("FAIL async_reset got %h/%b want %h/10", count_o, {zero_o, load_err_o}, 36'h0); n_err++; end
    #1 rst_i = 1'b0;
    step();
  endtask

`ifdef BCD_TIME_ALARM_EN
  task automatic test_alarm();
    int hits;
    int at;
    for (int pass = 0; pass < 2; pass++) begin
      hits = 0;
      at = -1;
      do_reset();
      alarm_val_i = 24'h000002;
      alarm_arm_i = (pass == 0);
      for (int i = 0; i < 2500; i++) begin
        do_tick();
        if (alarm_o === 1'b1) begin hits++; at = i; end
      end
      n_vec++; if (hits !== ((pass == 0) ? 1 : 0)) begin
        $display("FAIL alarm_pass%0d_hits got %0d want %0d", pass, hits, (pass == 0) ? 1 : 0); n_err++; end
      if (pass == 0) begin
        n_vec++; if (at !== 1999) begin $display("FAIL alarm_tick got %0d want 1999", at); n_err++; end
      end
    end
    alarm_arm_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_1000();
    test_carries();
    test_down();
    test_mode12();
    test_load_err();
    test_async_reset();
`ifdef BCD_TIME_ALARM_EN
    test_alarm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
